// File: rtl/ldpc_iter_ctrl_if.sv
// ldpc_iter_ctrl_if: message memory strobes and
// hard-decision readout handshake bundle.
interface ldpc_iter_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output rd_en,
    output rd_addr,
    output wr_en,
    output wr_addr,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  rd_en,
    input  rd_addr,
    input  wr_en,
    input  wr_addr,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/ldpc_iter_ctrl.sv
// ldpc_iter_ctrl: LDPC frame load / CNU / VNU / readout sequencer.
// Define LDPC_EARLY_TERM_EN for clean-syndrome early exit.
module ldpc_iter_ctrl #(
  parameter int ADDR_W   = 8,
  parameter int LEN_R12  = 256,
  parameter int LEN_R34  = 192,
  parameter int PIPE_LAT = 6,
  parameter int ITER_W   = 5,
  parameter int OUT_LEN  = 256
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_sync_in,
  input  logic              i_rate,
  input  logic [ITER_W-1:0] i_max_iter,
  input  logic              i_syn_err,
  ldpc_iter_ctrl_if.master  bus,
  output logic [4:0]        o_fsm_state,
  output logic              o_iter_0,
  output logic [ITER_W-1:0] o_num_iter,
  output logic              o_busy,
  output logic              o_finish,
  output logic              o_early_stop,
  output logic              o_frame_drop
);

  localparam int LEN_MAX =
    (LEN_R12 > LEN_R34) ? LEN_R12 : LEN_R34;
  localparam int PASS_MAX = LEN_MAX + PIPE_LAT;
  localparam int CNT_MAX =
    (PASS_MAX > OUT_LEN) ? PASS_MAX : OUT_LEN;
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  localparam logic [ADDR_W-1:0] A_LAST12 =
    ADDR_W'(LEN_R12 - 1);
  localparam logic [ADDR_W-1:0] A_LAST34 =
    ADDR_W'(LEN_R34 - 1);

  localparam logic [4:0] S_IDLE = 5'b00001;
  localparam logic [4:0] S_LOAD = 5'b00010;
  localparam logic [4:0] S_CNU  = 5'b00100;
  localparam logic [4:0] S_VNU  = 5'b01000;
  localparam logic [4:0] S_OUT  = 5'b10000;

  logic [4:0]        r_state;
  logic              r_sync_d;
  logic              r_rate;
  logic [ITER_W-1:0] r_max;
  logic [ITER_W-1:0] r_num;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_finish;
  logic              r_drop;
  logic              r_wen_sr [PIPE_LAT];
  logic [ADDR_W-1:0] r_wad_sr [PIPE_LAT];

  logic              w_idle;
  logic              w_load;
  logic              w_cnu;
  logic              w_vnu;
  logic              w_out;
  logic              w_rise;
  logic              w_pass;
  logic [CNT_W-1:0]  w_len;
  logic              w_rd_pass;
  logic              w_pass_end;
  logic              w_hs;
  logic              w_out_last;
  logic [ADDR_W-1:0] w_last_addr;
  logic [ADDR_W-1:0] w_rd_addr;
  logic              w_wr_en;
  logic [ITER_W-1:0] w_num_inc;
  logic              w_limit;
  logic              w_exit;

  assign w_idle = r_state[0];
  assign w_load = r_state[1];
  assign w_cnu  = r_state[2];
  assign w_vnu  = r_state[3];
  assign w_out  = r_state[4];

  assign w_rise = i_sync_in & ~r_sync_d;
  assign w_pass = w_cnu | w_vnu;

  assign w_len = r_rate ? CNT_W'(LEN_R34)
                        : CNT_W'(LEN_R12);

  assign w_rd_pass = w_pass & (r_cnt < w_len);

  // a pass lasts until the write of the last address retires
  assign w_pass_end = w_pass &
    (r_cnt == w_len + CNT_W'(PIPE_LAT - 1));

  assign w_hs = w_out & bus.out_ready;
  assign w_out_last = w_hs &
    (r_cnt == CNT_W'(OUT_LEN - 1));

  assign w_last_addr = r_rate ? A_LAST34 : A_LAST12;
  assign w_wr_en = r_wen_sr[PIPE_LAT-1];

  assign w_num_inc = (&r_num) ? r_num
                              : r_num + ITER_W'(1);

  assign w_limit =
    ({1'b0, r_num} + (ITER_W+1)'(1)) >= {1'b0, r_max};

  always_comb begin
    w_rd_addr = '0;
    if (w_out | w_rd_pass)
      w_rd_addr = r_cnt[ADDR_W-1:0];
    else if (w_pass)
      w_rd_addr = w_last_addr;
  end

`ifdef LDPC_EARLY_TERM_EN
  logic r_syn;
  logic r_early;
  logic w_clean;

  // include the final write's syndrome bit in the decision
  assign w_clean = ~(r_syn | (w_wr_en & i_syn_err));
  assign w_exit = w_limit | w_clean;
  assign o_early_stop = r_early;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_syn   <= 1'b0;
      r_early <= 1'b0;
    end else begin
      if (w_idle & w_rise)
        r_early <= 1'b0;
      else if (w_vnu & w_pass_end & w_clean & ~w_limit)
        r_early <= 1'b1;
      if (w_cnu & w_pass_end)
        r_syn <= 1'b0;
      else if (w_vnu & w_wr_en & i_syn_err)
        r_syn <= 1'b1;
    end
  end
`else
  logic w_unused_syn;

  assign w_unused_syn = i_syn_err;
  assign w_exit = w_limit;
  assign o_early_stop = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      r_sync_d <= 1'b0;
      r_rate   <= 1'b0;
      r_max    <= '0;
      r_num    <= '0;
      r_cnt    <= '0;
      r_finish <= 1'b0;
      r_drop   <= 1'b0;
    end else begin
      r_sync_d <= i_sync_in;
      r_drop   <= w_rise & ~w_idle;
      r_finish <= w_out_last;
      unique case (1'b1)
        w_idle: begin
          if (w_rise) begin
            r_state <= S_LOAD;
            r_rate  <= i_rate;
            r_max   <= (i_max_iter == '0) ? ITER_W'(1)
                                          : i_max_iter;
            r_num   <= '0;
            r_cnt   <= '0;
          end
        end
        w_load: begin
          if (!i_sync_in) begin
            r_state <= S_CNU;
            r_cnt   <= '0;
          end
        end
        w_cnu: begin
          if (w_pass_end) begin
            r_state <= S_VNU;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        w_vnu: begin
          if (w_pass_end) begin
            r_num   <= w_num_inc;
            r_cnt   <= '0;
            r_state <= w_exit ? S_OUT : S_CNU;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        w_out: begin
          if (w_hs) begin
            if (w_out_last) begin
              r_state <= S_IDLE;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // only pass reads enter the write pipe, never readout reads
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < PIPE_LAT; i++) begin
        r_wen_sr[i] <= 1'b0;
        r_wad_sr[i] <= '0;
      end
    end else begin
      r_wen_sr[0] <= w_rd_pass;
      r_wad_sr[0] <= w_rd_addr;
      for (int i = 1; i < PIPE_LAT; i++) begin
        r_wen_sr[i] <= r_wen_sr[i-1];
        r_wad_sr[i] <= r_wad_sr[i-1];
      end
    end
  end

  assign bus.rd_en     = w_rd_pass | w_hs;
  assign bus.rd_addr   = w_rd_addr;
  assign bus.wr_en     = w_wr_en;
  assign bus.wr_addr   = r_wad_sr[PIPE_LAT-1];
  assign bus.out_valid = w_out;

  assign o_fsm_state  = r_state;
  assign o_iter_0     = w_cnu & (r_num == '0);
  assign o_num_iter   = r_num;
  assign o_busy       = ~w_idle;
  assign o_finish     = r_finish;
  assign o_frame_drop = r_drop;

endmodule

// File: tb/tb_ldpc_iter_ctrl.sv
// tb_ldpc_iter_ctrl: randomized frames against a timeline model
// of the iteration controller.
module tb_ldpc_iter_ctrl;

  localparam int AW  = 8;
  localparam int L12 = 256;
  localparam int L34 = 192;
  localparam int P   = 6;
  localparam int IW  = 5;
  localparam int OL  = 256;

  localparam int PH_IDLE = 0;
  localparam int PH_LOAD = 1;
  localparam int PH_DEC  = 2;
  localparam int PH_OUT  = 3;

`ifdef LDPC_EARLY_TERM_EN
  localparam bit ET = 1'b1;
`else
  localparam bit ET = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sync_in = 1'b0;
  logic rate = 1'b0;
  logic syn_err = 1'b0;
  logic out_ready = 1'b0;
  logic [IW-1:0] max_iter = '0;

  logic [4:0]    fsm_state;
  logic          iter_0;
  logic [IW-1:0] num_iter;
  logic          busy;
  logic          finish;
  logic          early_stop;
  logic          frame_drop;

  ldpc_iter_ctrl_if #(.ADDR_W(AW)) bus_if ();
  assign bus_if.out_ready = out_ready;

  ldpc_iter_ctrl #(
    .ADDR_W(AW), .LEN_R12(L12), .LEN_R34(L34),
    .PIPE_LAT(P), .ITER_W(IW), .OUT_LEN(OL)
  ) dut (
    .i_clk(clk),
    .i_reset(reset),
    .i_sync_in(sync_in),
    .i_rate(rate),
    .i_max_iter(max_iter),
    .i_syn_err(syn_err),
    .bus(bus_if),
    .o_fsm_state(fsm_state),
    .o_iter_0(iter_0),
    .o_num_iter(num_iter),
    .o_busy(busy),
    .o_finish(finish),
    .o_early_stop(early_stop),
    .o_frame_drop(frame_drop)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;

  // model state
  int m_phase = PH_IDLE;
  int m_t = 0;
  int m_L = L12;
  int m_nit = 1;
  int m_hs = 0;
  int m_num = 0;
  bit m_early = 0;
  bit m_early_pend = 0;
  bit m_finish = 0;
  bit m_drop = 0;
  bit m_prev = 0;
  bit m_valid = 0;

  // stimulus knobs
  int cur_clean = 0;
  int rdy_mode = 0;
  int drop_t = -1;
  bit collide = 0;
  int bad_pos = P;

  // observed activity counters
  int c_wr = 0;
  int c_hs = 0;
  int c_fin = 0;
  int c_drop = 0;

  function automatic void check(string nm,
                                logic [31:0] act,
                                logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d at %0t",
               nm, act, exp, $time);
    end
  endfunction

  task automatic model_step();
    bit rise;
    int mx;
    if (reset) begin
      m_phase = PH_IDLE;
      m_num = 0;
      m_early = 0;
      m_finish = 0;
      m_drop = 0;
      m_prev = 0;
      m_t = 0;
      m_hs = 0;
      m_valid = 1;
    end else begin
      rise = sync_in && !m_prev;
      m_prev = sync_in;
      m_drop = rise && (m_phase != PH_IDLE);
      m_finish = 0;
      case (m_phase)
        PH_IDLE: if (rise) begin
          m_phase = PH_LOAD;
          m_L = rate ? L34 : L12;
          mx = (max_iter == 0) ? 1 : int'(max_iter);
          m_early_pend = ET && cur_clean != 0
                         && cur_clean < mx;
          m_nit = m_early_pend ? cur_clean : mx;
          m_num = 0;
          m_early = 0;
        end
        PH_LOAD: if (!sync_in) begin
          m_phase = PH_DEC;
          m_t = 0;
        end
        PH_DEC: begin
          m_t++;
          if (m_t == 2 * m_nit * (m_L + P)) begin
            m_phase = PH_OUT;
            m_hs = 0;
            m_num = m_nit;
            m_early = m_early_pend;
          end
        end
        default: if (out_ready) begin
          m_hs++;
          if (m_hs == OL) begin
            m_phase = PH_IDLE;
            m_finish = 1;
          end
        end
      endcase
    end
  endtask

  task automatic drive();
    int k;
    int pos;
    syn_err = 1'($urandom % 2);
    if (m_phase == PH_DEC) begin
      k = m_t / (m_L + P);
      pos = m_t % (m_L + P);
      if (k % 2 == 1 && pos >= P) begin
        if (k / 2 + 1 == cur_clean)
          syn_err = 1'b0;
        else
          syn_err = (pos == bad_pos) || ($urandom % 8 == 0);
      end
      if (drop_t >= 0)
        sync_in = (m_t == drop_t);
    end
    if (rdy_mode == 1)
      out_ready = ~out_ready;
    else if (rdy_mode == 2)
      out_ready = 1'b1;
    else
      out_ready = 1'($urandom % 2);
    if (m_phase == PH_OUT && collide && out_ready
        && m_hs == OL - 1)
      sync_in = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    drive();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (m_phase != PH_IDLE && n < 30000) begin
      step();
      n++;
    end
    if (m_phase != PH_IDLE) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: phase %0d want %0d",
               m_phase, PH_IDLE);
    end
  endtask

  task automatic run_frame(input bit r, input int mx,
                           input int clean, input int rm,
                           input int dt, input bit coll);
    sync_in = 1'b0;
    step();
    rate = r;
    max_iter = IW'(mx);
    cur_clean = clean;
    rdy_mode = rm;
    drop_t = dt;
    collide = coll;
    bad_pos = $urandom_range(P, L34 + P - 1);
    c_wr = 0;
    c_hs = 0;
    c_fin = 0;
    c_drop = 0;
    sync_in = 1'b1;
    repeat ($urandom_range(1, 4)) step();
    sync_in = 1'b0;
    wait_idle();
    sync_in = 1'b0;
    step();
    step();
  endtask

  // per-cycle comparison against the timeline model
  initial begin : cmp
    int k;
    int pos;
    logic [4:0] e_st;
    bit e_rd, e_wr, e_ov, e_bz, e_i0;
    int e_num, e_ra, e_wa;
    forever begin
      @(negedge clk);
      if (m_valid) begin
        e_st = 5'b00001;
        e_rd = 0; e_wr = 0; e_ov = 0; e_bz = 0; e_i0 = 0;
        e_num = m_num; e_ra = 0; e_wa = 0;
        case (m_phase)
          PH_LOAD: begin
            e_st = 5'b00010;
            e_bz = 1;
          end
          PH_DEC: begin
            k = m_t / (m_L + P);
            pos = m_t % (m_L + P);
            e_st = (k % 2 == 1) ? 5'b01000 : 5'b00100;
            e_bz = 1;
            e_rd = pos < m_L;
            e_ra = pos;
            e_wr = pos >= P;
            e_wa = pos - P;
            e_i0 = k == 0;
            e_num = k / 2;
          end
          PH_OUT: begin
            e_st = 5'b10000;
            e_bz = 1;
            e_ov = 1;
            e_rd = out_ready;
            e_ra = m_hs;
          end
          default: ;
        endcase
        check("fsm_state", 32'(fsm_state), 32'(e_st));
        check("rd_en", 32'(bus_if.rd_en), 32'(e_rd));
        check("wr_en", 32'(bus_if.wr_en), 32'(e_wr));
        check("out_valid", 32'(bus_if.out_valid), 32'(e_ov));
        check("busy", 32'(busy), 32'(e_bz));
        check("iter_0", 32'(iter_0), 32'(e_i0));
        check("num_iter", 32'(num_iter), 32'(e_num));
        check("early_stop", 32'(early_stop), 32'(m_early));
        check("finish", 32'(finish), 32'(m_finish));
        check("frame_drop", 32'(frame_drop), 32'(m_drop));
        if (e_rd || e_ov)
          check("rd_addr", 32'(bus_if.rd_addr), 32'(e_ra));
        if (e_wr)
          check("wr_addr", 32'(bus_if.wr_addr), 32'(e_wa));
        c_wr += int'(bus_if.wr_en);
        c_hs += int'(bus_if.rd_en & bus_if.out_valid);
        c_fin += int'(finish);
        c_drop += int'(frame_drop);
      end
    end
  end

  initial begin : main
    int n;
    reset = 1'b1;
    repeat (3) step();
    check("rst_fsm", 32'(fsm_state), 32'd1);
    check("rst_rd_en", 32'(bus_if.rd_en), 32'd0);
    check("rst_rd_addr", 32'(bus_if.rd_addr), 32'd0);
    check("rst_wr_en", 32'(bus_if.wr_en), 32'd0);
    check("rst_wr_addr", 32'(bus_if.wr_addr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_num", 32'(num_iter), 32'd0);
    reset = 1'b0;
    step();

    // three full iterations at rate 1/2
    run_frame(1'b0, 3, 0, 2, -1, 1'b0);
    check("t1_num", 32'(num_iter), 32'd3);
    check("t1_wr_cnt", 32'(c_wr), 32'd1536);
    check("t1_hs", 32'(c_hs), 32'd256);
    check("t1_fin", 32'(c_fin), 32'd1);

    // clean syndrome in iteration 2 at rate 3/4
    run_frame(1'b1, 10, 2, 0, -1, 1'b0);
    check("t2_num", 32'(num_iter), ET ? 32'd2 : 32'd10);
    check("t2_early", 32'(early_stop), ET ? 32'd1 : 32'd0);
    check("t2_wr_cnt", 32'(c_wr), ET ? 32'd768 : 32'd3840);

    // readout with out_ready toggling
    run_frame(1'b0, 1, 0, 1, -1, 1'b0);
    check("t3_hs", 32'(c_hs), 32'd256);
    check("t3_fin", 32'(c_fin), 32'd1);

    // max_iter=0 runs once; frame dropped during VNU
    run_frame(1'b1, 0, 0, 0, L34 + P + 20, 1'b0);
    check("t4_num", 32'(num_iter), 32'd1);
    check("t4_drop", 32'(c_drop), 32'd1);
    check("t4_wr_cnt", 32'(c_wr), 32'd384);

    // reset in the middle of the first VNU pass
    sync_in = 1'b0;
    step();
    rate = 1'b0;
    max_iter = IW'(3);
    cur_clean = 0;
    drop_t = -1;
    collide = 1'b0;
    sync_in = 1'b1;
    step();
    sync_in = 1'b0;
    n = 0;
    while (!(m_phase == PH_DEC && m_t == L12 + P + 40)
           && n < 5000) begin
      step();
      n++;
    end
    check("t5_in_vnu", 32'(fsm_state), 32'b01000);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t5_fsm", 32'(fsm_state), 32'd1);
    check("t5_rd_en", 32'(bus_if.rd_en), 32'd0);
    check("t5_wr_en", 32'(bus_if.wr_en), 32'd0);
    check("t5_num", 32'(num_iter), 32'd0);
    run_frame(1'b0, 2, 1, 0, -1, 1'b0);
    check("t5_num2", 32'(num_iter), ET ? 32'd1 : 32'd2);

    // sync_in rise on the edge returning to IDLE
    run_frame(1'b1, 1, 0, 2, -1, 1'b1);
    check("t6_drop", 32'(c_drop), 32'd1);
    check("t6_fin", 32'(c_fin), 32'd1);

    for (int f = 0; f < 6; f++) begin
      run_frame(1'($urandom % 2), $urandom_range(0, 4),
                $urandom_range(0, 5), $urandom_range(0, 2),
                ($urandom % 2 == 0) ? -1
                  : $urandom_range(0, 1500),
                1'($urandom % 2));
      check("rnd_fin", 32'(c_fin), 32'd1);
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
